// File: rtl/msx_audio_dac.sv
// Stereo PCM -> 1-bit pulse-density DAC: hold, one-pole smoothing, cassette mix with saturation, 1st-order delta-sigma.
// Optional dither build: define AUDIO_DITHER_EN to add a shared 16-bit LFSR dither term.

module msx_audio_dac_ch #(
  parameter int PCM_W        = 16,
  parameter int SMOOTH_SHIFT = 4,
  parameter int CMT_LEVEL    = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_sample_stb,
  input  logic [PCM_W-1:0]        i_pcm,
  input  logic                    i_cmt_in,
  input  logic                    i_tape_en,
  input  logic                    i_mute,
  input  logic signed [4:0]       i_dither,
  output logic                    o_audio,
  output logic                    o_clip
);
  localparam int FW = PCM_W + SMOOTH_SHIFT;
  localparam logic signed [PCM_W:0]   CMT  = (PCM_W+1)'(CMT_LEVEL);
  localparam logic [PCM_W-1:0]        MAXV = {1'b0, {(PCM_W-1){1'b1}}};
  localparam logic [PCM_W-1:0]        MINV = {1'b1, {(PCM_W-1){1'b0}}};

  logic signed [PCM_W-1:0] r_x;
  logic signed [FW-1:0]    r_f;
  logic signed [PCM_W-1:0] r_m;
  logic [PCM_W-1:0]        r_acc;
  logic                    r_audio;
  logic                    r_clip;

  logic signed [PCM_W-1:0] w_t;
  logic signed [FW:0]      w_text;
  logic signed [FW:0]      w_fext;
  logic signed [FW:0]      w_diff;
  logic signed [FW:0]      w_step;
  logic signed [PCM_W-1:0] w_y;
  logic signed [PCM_W:0]   w_cmt;
  logic [PCM_W:0]          w_s;
  logic                    w_ovf;
  logic [PCM_W-1:0]        w_sat;
  logic [PCM_W-1:0]        w_u;
  logic [PCM_W+1:0]        w_sum;

  assign w_t    = i_mute ? '0 : r_x;
  // Difference is one bit wider than the accumulator so a full-scale step cannot wrap.
  assign w_text = {{(SMOOTH_SHIFT+1){w_t[PCM_W-1]}}, w_t};
  assign w_fext = {r_f[FW-1], r_f};
  assign w_diff = (w_text <<< SMOOTH_SHIFT) - w_fext;
  assign w_step = w_diff >>> SMOOTH_SHIFT;
  assign w_y    = r_f[FW-1:SMOOTH_SHIFT];

  assign w_cmt  = i_tape_en ? (i_cmt_in ? CMT : -CMT) : '0;
  assign w_s    = {w_y[PCM_W-1], w_y} + w_cmt;
  assign w_ovf  = w_s[PCM_W] ^ w_s[PCM_W-1];
  assign w_sat  = w_ovf ? (w_s[PCM_W] ? MINV : MAXV) : w_s[PCM_W-1:0];

  // Offset-binary input; a negative sum (only reachable through dither) floors the accumulator.
  assign w_u    = {~r_m[PCM_W-1], r_m[PCM_W-2:0]};
  assign w_sum  = {2'b00, r_acc} + {2'b00, w_u} + {{(PCM_W-3){i_dither[4]}}, i_dither};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x     <= '0;
      r_f     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_audio <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      if (i_sample_stb)
        r_x <= i_pcm;
      r_f     <= r_f + w_step[FW-1:0];
      r_m     <= w_sat;
      r_clip  <= w_ovf;
      r_audio <= ~w_sum[PCM_W+1] & w_sum[PCM_W];
      r_acc   <= w_sum[PCM_W+1] ? '0 : w_sum[PCM_W-1:0];
    end
  end

  assign o_audio = r_audio;
  assign o_clip  = r_clip;
endmodule

module msx_audio_dac #(
  parameter int PCM_W        = 16,
  parameter int SMOOTH_SHIFT = 4,
  parameter int CMT_LEVEL    = 4096
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             sample_stb,
  input  logic [PCM_W-1:0] pcm_l,
  input  logic [PCM_W-1:0] pcm_r,
  input  logic             cmt_in,
  input  logic             tape_en,
  input  logic             mute,
  output logic             audio_l,
  output logic             audio_r,
  output logic             clip_l,
  output logic             clip_r
);
  logic signed [4:0] w_dither;

`ifdef AUDIO_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  // Fibonacci taps 16,14,13,11.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      r_lfsr <= 16'hACE1;
    else
      r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign w_dither = 5'({1'b0, r_lfsr[3:0]}) - 5'd8;
`else
  assign w_dither = 5'sd0;
`endif

  msx_audio_dac_ch #(
    .PCM_W(PCM_W), .SMOOTH_SHIFT(SMOOTH_SHIFT), .CMT_LEVEL(CMT_LEVEL)
  ) u_ch_l (
    .i_clk(clk_sys), .i_reset_n(reset_n), .i_sample_stb(sample_stb), .i_pcm(pcm_l),
    .i_cmt_in(cmt_in), .i_tape_en(tape_en), .i_mute(mute), .i_dither(w_dither),
    .o_audio(audio_l), .o_clip(clip_l)
  );

  msx_audio_dac_ch #(
    .PCM_W(PCM_W), .SMOOTH_SHIFT(SMOOTH_SHIFT), .CMT_LEVEL(CMT_LEVEL)
  ) u_ch_r (
    .i_clk(clk_sys), .i_reset_n(reset_n), .i_sample_stb(sample_stb), .i_pcm(pcm_r),
    .i_cmt_in(cmt_in), .i_tape_en(tape_en), .i_mute(mute), .i_dither(w_dither),
    .o_audio(audio_r), .o_clip(clip_r)
  );
endmodule

// File: tb/tb_msx_audio_dac.sv
// Bench for msx_audio_dac: integer reference model feeds an expected-output queue; a monitor pops and compares every cycle.
module tb_msx_audio_dac;
  localparam int S = 4;
  localparam int L = 4096;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_stb = 1'b0;
  logic [15:0] pcm_l = '0;
  logic [15:0] pcm_r = '0;
  logic        cmt_in = 1'b0;
  logic        tape_en = 1'b0;
  logic        mute = 1'b0;
  logic        audio_l, audio_r, clip_l, clip_r;

  always #5 clk_sys = ~clk_sys;

  msx_audio_dac #(.PCM_W(16), .SMOOTH_SHIFT(S), .CMT_LEVEL(L)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sample_stb(sample_stb),
    .pcm_l(pcm_l), .pcm_r(pcm_r), .cmt_in(cmt_in), .tape_en(tape_en), .mute(mute),
    .audio_l(audio_l), .audio_r(audio_r), .clip_l(clip_l), .clip_r(clip_r)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0] exp_q[$];

  // Reference model state: per channel held sample, filter accumulator, mixer output, modulator accumulator.
  int     mx[2];
  longint mf[2];
  int     mm[2];
  int     macc[2];
  bit     maud[2];
  bit     mclip[2];
  logic [15:0] mlfsr = 16'hACE1;

  // Stimulus state, applied by tick().
  bit g_rst = 1'b0, g_stb = 1'b0, g_cmt = 1'b0, g_tape = 1'b0, g_mute = 1'b0;
  int g_pl = 0, g_pr = 0;
  int ones_l, ones_r, clips_l, clips_r;

  task automatic model_step();
    int pcm[2];
    int d, t, y, s, nm, u, sum;
    longint nf;
    bit fb;
    pcm[0] = g_pl;
    pcm[1] = g_pr;
    if (!g_rst) begin
      for (int c = 0; c < 2; c++) begin
        mx[c] = 0; mf[c] = 0; mm[c] = 0; macc[c] = 0; maud[c] = 0; mclip[c] = 0;
      end
      mlfsr = 16'hACE1;
    end else begin
      d = 0;
`ifdef AUDIO_DITHER_EN
      d = int'(mlfsr[3:0]) - 8;
`endif
      for (int c = 0; c < 2; c++) begin
        t  = g_mute ? 0 : mx[c];
        y  = int'(mf[c] >>> S);
        nf = mf[c] + (((longint'(t) <<< S) - mf[c]) >>> S);
        s  = y + (g_tape ? (g_cmt ? L : -L) : 0);
        nm = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        u  = mm[c] + 32768;
        sum = macc[c] + u + d;
        maud[c]  = (sum >= 65536);
        macc[c]  = (sum < 0) ? 0 : (sum % 65536);
        mclip[c] = (s != nm);
        mm[c]    = nm;
        mf[c]    = nf;
        if (g_stb) mx[c] = pcm[c];
      end
      fb = mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10];
      mlfsr = {mlfsr[14:0], fb};
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    reset_n    = g_rst;
    sample_stb = g_stb;
    pcm_l      = 16'(g_pl);
    pcm_r      = 16'(g_pr);
    cmt_in     = g_cmt;
    tape_en    = g_tape;
    mute       = g_mute;
    model_step();
    exp_q.push_back({maud[0], maud[1], mclip[0], mclip[1]});
    @(posedge clk_sys);
    #1;
    cyc++;
    ones_l  += int'(audio_l);
    ones_r  += int'(audio_r);
    clips_l += int'(clip_l);
    clips_r += int'(clip_r);
  endtask

  task automatic run(input int n);
    ones_l = 0; ones_r = 0; clips_l = 0; clips_r = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int pl, input int pr);
    g_pl = pl; g_pr = pr; g_stb = 1'b1;
    tick();
    g_stb = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: outputs are valid every cycle, so each post-edge sample consumes one expectation.
  initial begin
    logic [3:0] e, a;
    forever begin
      @(posedge clk_sys);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {audio_l, audio_r, clip_l, clip_r};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs cyc %0d: {audio_l,audio_r,clip_l,clip_r} got %b required %b", cyc, a, e);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [15:0] r16;

    // Reset held with a full-scale strobe present: every output stays low.
    g_rst = 1'b0; g_pl = 32767; g_pr = 32767; g_stb = 1'b1;
    run(8);
    chk("reset_audio_ones", ones_l + ones_r, 0, 0);
    chk("reset_clips", clips_l + clips_r, 0, 0);

    // Release without a strobe: x remains 0, so the modulator idles at 50%.
    g_rst = 1'b1; g_stb = 1'b0;
    run(20);
`ifndef AUDIO_DITHER_EN
    chk("no_capture_duty_l", ones_l, 10, 10);
`endif

    // Step to 0x1000 and let the filter settle.
    strobe(16'h1000, 0);
    run(400);
    run(1024);
`ifndef AUDIO_DITHER_EN
    chk("step_duty_l", ones_l, 575, 576);
    chk("zero_duty_r", ones_r, 512, 512);
`endif

    // Saturation on the right channel with cassette high, then cassette low.
    g_tape = 1'b1; g_cmt = 1'b1;
    strobe(0, 16'h7800);
    run(400);
    run(1024);
    chk("sat_clip_r", clips_r, 1024, 1024);
    chk("sat_clip_l", clips_l, 0, 0);
`ifndef AUDIO_DITHER_EN
    chk("sat_duty_r", ones_r, 1023, 1024);
`endif
    g_cmt = 1'b0;
    run(1024);
    chk("nosat_clip_r", clips_r, 0, 0);
`ifndef AUDIO_DITHER_EN
    chk("nosat_duty_r", ones_r, 927, 928);
`endif

    // Mute with a steady 0x4000, strobe coincident with mute, then release.
    g_tape = 1'b0; g_mute = 1'b1;
    strobe(16'h4000, 16'h4000);
    run(400);
    run(1024);
`ifndef AUDIO_DITHER_EN
    chk("mute_duty_l", ones_l, 512, 512);
`endif
    g_mute = 1'b0;
    run(400);
    run(1024);
`ifndef AUDIO_DITHER_EN
    chk("unmute_duty_l", ones_l, 767, 768);
`endif

    // Randomized traffic including mid-stream resets and full-scale samples.
    for (int i = 0; i < 3000; i++) begin
      g_rst = ($urandom_range(0, 199) != 0);
      g_stb = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: g_pl = 32767;
        1: g_pl = -32768;
        default: begin r16 = 16'($urandom); g_pl = int'(r16); end
      endcase
      r16 = 16'($urandom);
      g_pr = int'(r16);
      g_cmt = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 31) == 0) g_tape = ~g_tape;
      if ($urandom_range(0, 63) == 0) g_mute = ~g_mute;
      tick();
    end

    g_rst = 1'b1; g_stb = 1'b0;
    run(4);
    @(posedge clk_sys);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
